instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Pipeline fetch stage that feeds the decode stage. Holds the program counter and issues single-outstanding requests to instruction memory over a req/ack handshake. Registers each returned instruction with its PC+4 and a valid enable for decode. Handles redirects from decode's branch resolution and stall requests from the hazard unit.

Parameters:
INST_SIZE, 32, instruction width; also the width of o_pcplus4.
ADDR_SIZE, 32, fetch address width; must equal INST_SIZE.
RESET_ADDR, 0, first PC fetched after reset; must be word aligned.

Ports:
i_aclk  in  1  system clock
i_areset_n  in  1  asynchronous active-low reset
i_stall  in  1  hazard unit: do not present a new instruction to decode
i_branch_valid  in  1  decode: branch taken or jump this cycle
i_branch_addr  in  ADDR_SIZE  decode: redirect target
o_imem_req  out  1  instruction memory request
o_imem_addr  out  ADDR_SIZE  request address; stable while o_imem_req=1 and no ack
i_imem_ack  in  1  one-cycle ack; i_imem_rdata valid in the same cycle
i_imem_rdata  in  INST_SIZE  fetched instruction
o_instruction  out  INST_SIZE  instruction to decode
o_pcplus4  out  INST_SIZE  address of o_instruction plus 4
o_en  out  1  o_instruction is valid; 0 means decode inserts a NOOP

Behaviour:
- Clock i_aclk; reset i_areset_n is asynchronous and active-low. All state is in flops with async clear.
- Reset values: state=S_IDLE, pc=RESET_ADDR, req_addr=RESET_ADDR, o_en=0, o_instruction=32'h0000_0013 (NOOP_CODE, ADDI x0,x0,0), o_pcplus4=0, hold buffer=NOOP, o_imem_req=0.
- o_imem_req=1 only in S_FETCH or S_FLUSH. o_imem_addr=req_addr.
- Registers: pc is the next address to request. req_addr is the address in flight.
- Branch target: i_branch_addr[1:0] is forced to 2'b00.
- Addresses wrap modulo 2^ADDR_SIZE, so 0xFFFF_FFFC+4 = 0.
- S_IDLE: req=0. Moves to S_FETCH after one cycle. A branch in this cycle sets pc and req_addr to the target.
- S_FETCH, ack and no branch and no stall: o_instruction<=rdata, o_pcplus4<=req_addr+4, o_en<=1, req_addr<=req_addr+4. Stays in S_FETCH, so sustained throughput is 1 instruction per ack.
- S_FETCH, ack and stall and no branch: hold buffer<=rdata, hold_pc4<=req_addr+4, o_en<=0, req_addr<=req_addr+4, go to S_HOLD.
- S_FETCH, no ack: o_en<=0 (bubble). Address is held.
- S_FETCH, branch with no ack: req_addr cannot change. pc<=target, o_en<=0, go to S_FLUSH.
- S_FETCH, branch with ack in the same cycle: rdata is discarded, o_en<=0, req_addr<=target, stay in S_FETCH.
- S_FLUSH: req stays at the old req_addr and o_en=0. On ack, data is discarded, req_addr<=pc, go to S_FETCH. A further branch while in S_FLUSH updates pc only (last target wins).
- S_HOLD: req=0.
  - Stall deasserted: o_instruction<=buffer, o_pcplus4<=hold_pc4, o_en<=1, go to S_FETCH.
  - Stall held: o_en=0, buffer kept.
- Priority: branch > stall > ack.
  - A branch in S_HOLD discards the buffer, sets req_addr<=target, o_en<=0, go to S_FETCH.
  - A branch in any state forces o_en=0 on the following cycle, so the wrong-path instruction is squashed.
- o_instruction and o_pcplus4 hold their last values whenever o_en<=0. Decode ignores them in that case.
- Reset asserted mid-request: o_imem_req drops immediately (async). A late ack after reset release is ignored because the state is S_IDLE.

Optional Feature:
FETCH_PERF_EN
- Defined: adds two outputs, both cleared by reset, saturating at all-ones.
  - o_fetch_cnt [31:0]: increments on every instruction delivered with o_en<=1.
  - o_squash_cnt [31:0]: increments on every discarded rdata or buffer due to a branch.
- Undefined: these ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- Reset, RESET_ADDR=0x100, memory acks every cycle: first request to 0x100 one cycle after reset release, then 0x104, 0x108. o_en=1 each cycle after the first ack, with o_pcplus4=0x104, 0x108, 0x10C.
- Branch to 0x203 while request to 0x108 is unacked, ack 3 cycles later: addr stays 0x108 until ack and that data is discarded. Next request is 0x200, and o_en stays 0 until the 0x200 data arrives with o_pcplus4=0x204.
- Stall high for 2 cycles as 0x10C data is acked: req=0 and o_en=0 for 2 cycles. Then o_instruction=the 0x10C data with o_pcplus4=0x110, and the next request is 0x110.
- Branch and ack in the same cycle from S_FETCH, target 0x40: that cycle's rdata is never presented, and the next request is 0x40.
- Wrap: pc 0xFFFF_FFFC acked gives o_pcplus4=0 and a next request to 0x0.
- With FETCH_PERF_EN defined: 5 deliveries and 2 squashes give o_fetch_cnt=5 and o_squash_cnt=2. Both read 0 after reset.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time and
// registers instructions for decode. Optional perf counters under FETCH_PERF_EN.
module instr_fetch #(
  parameter int unsigned            INST_SIZE  = 32,
  parameter int unsigned            ADDR_SIZE  = 32,
  parameter logic [ADDR_SIZE-1:0]   RESET_ADDR = '0
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_stall,
  input  logic                 i_branch_valid,
  input  logic [ADDR_SIZE-1:0] i_branch_addr,
  output logic                 o_imem_req,
  output logic [ADDR_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_ack,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0]          o_fetch_cnt,
  output logic [31:0]          o_squash_cnt,
`endif
  output logic [INST_SIZE-1:0] o_instruction,
  output logic [INST_SIZE-1:0] o_pcplus4,
  output logic                 o_en
);

  localparam logic [INST_SIZE-1:0] NoopCode = INST_SIZE'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StFetch, StFlush, StHold} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   pc_q, pc_d;
  logic [ADDR_SIZE-1:0]   req_addr_q, req_addr_d;
  logic                   en_q, en_d;
  logic [INST_SIZE-1:0]   instr_q, instr_d;
  logic [INST_SIZE-1:0]   pc4_q, pc4_d;
  logic [INST_SIZE-1:0]   buf_q, buf_d;
  logic [INST_SIZE-1:0]   hold_pc4_q, hold_pc4_d;
  logic                   squash;
  logic [ADDR_SIZE-1:0]   target;
  logic [ADDR_SIZE-1:0]   req_plus4;
  logic [1:0]             unused_branch_lo;

  assign target           = {i_branch_addr[ADDR_SIZE-1:2], 2'b00};
  assign unused_branch_lo = i_branch_addr[1:0];
  assign req_plus4        = req_addr_q + ADDR_SIZE'(4);

  assign o_imem_req    = (state_q == StFetch) || (state_q == StFlush);
  assign o_imem_addr   = req_addr_q;
  assign o_instruction = instr_q;
  assign o_pcplus4     = pc4_q;
  assign o_en          = en_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    en_d       = 1'b0;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    buf_d      = buf_q;
    hold_pc4_d = hold_pc4_q;
    squash     = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (i_branch_valid) begin
          pc_d       = target;
          req_addr_d = target;
        end
      end
      StFetch: begin
        if (i_branch_valid) begin
          pc_d = target;
          if (i_imem_ack) begin
            req_addr_d = target;
            squash     = 1'b1;
          end else begin
            // Request address must stay stable until the ack, so park the target.
            state_d = StFlush;
          end
        end else if (i_imem_ack) begin
          req_addr_d = req_plus4;
          pc_d       = req_plus4;
          if (i_stall) begin
            buf_d      = i_imem_rdata;
            hold_pc4_d = INST_SIZE'(req_plus4);
            state_d    = StHold;
          end else begin
            instr_d = i_imem_rdata;
            pc4_d   = INST_SIZE'(req_plus4);
            en_d    = 1'b1;
          end
        end
      end
      StFlush: begin
        if (i_branch_valid) begin
          pc_d = target;
        end
        if (i_imem_ack) begin
          squash     = 1'b1;
          req_addr_d = i_branch_valid ? target : pc_q;
          pc_d       = req_addr_d;
          state_d    = StFetch;
        end
      end
      StHold: begin
        if (i_branch_valid) begin
          squash     = 1'b1;
          req_addr_d = target;
          pc_d       = target;
          state_d    = StFetch;
        end else if (!i_stall) begin
          instr_d = buf_q;
          pc4_d   = hold_pc4_q;
          en_d    = 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      en_q       <= 1'b0;
      instr_q    <= NoopCode;
      pc4_q      <= '0;
      buf_q      <= NoopCode;
      hold_pc4_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      en_q       <= en_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      buf_q      <= buf_d;
      hold_pc4_q <= hold_pc4_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, squash_cnt_q;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (en_d && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (squash && (squash_cnt_q != '1)) begin
        squash_cnt_q <= squash_cnt_q + 32'd1;
      end
    end
  end

  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_squash_cnt = squash_cnt_q;
`else
  logic unused_squash;
  assign unused_squash = squash;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver pushes expected deliveries, a
// monitor pops them whenever o_en is high.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        en;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, squash_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .INST_SIZE (32),
    .ADDR_SIZE (32),
    .RESET_ADDR(32'h0000_0100)
  ) dut (
    .i_aclk        (clk),
    .i_areset_n    (rst_n),
    .i_stall       (stall),
    .i_branch_valid(br),
    .i_branch_addr (br_addr),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_ack    (ack),
    .i_imem_rdata  (rdata),
`ifdef FETCH_PERF_EN
    .o_fetch_cnt   (fetch_cnt),
    .o_squash_cnt  (squash_cnt),
`endif
    .o_instruction (instr),
    .o_pcplus4     (pc4),
    .o_en          (en)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every presented instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && en === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_en", 64'd1, 64'd0);
      end else begin
        check("deliver", {instr, pc4}, sb_q.pop_front());
      end
    end
  end

  // One cycle: check the request, then drive ack/stall/branch for this cycle.
  task automatic step(input logic a, input logic s, input logic b, input logic [31:0] tgt,
                      input logic exp_req, input logic [31:0] exp_addr, input logic push);
    @(negedge clk);
    check("imem_req", {63'd0, req}, {63'd0, exp_req});
    if (exp_req) check("imem_addr", {32'd0, addr}, {32'd0, exp_addr});
    ack     = a;
    rdata   = ~addr;
    stall   = s;
    br      = b;
    br_addr = tgt;
    if (push) sb_q.push_back({~exp_addr, exp_addr + 32'd4});
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {63'd0, req}, 64'd0);
    check("rst_en", {63'd0, en}, 64'd0);
    check("rst_instr", {32'd0, instr}, 64'h13);
    check("rst_pc4", {32'd0, pc4}, 64'd0);
    rst_n = 1'b1;
    // Sequential fetch from RESET_ADDR.
    step(1, 0, 0, 0, 1, 32'h100, 1);
    step(1, 0, 0, 0, 1, 32'h104, 1);
    // Branch (misaligned target) while 0x108 is outstanding; ack arrives later.
    step(0, 0, 1, 32'h203, 1, 32'h108, 0);
    step(0, 0, 0, 0, 1, 32'h108, 0);
    step(0, 0, 0, 0, 1, 32'h108, 0);
    step(1, 0, 0, 0, 1, 32'h108, 0);
    step(1, 0, 0, 0, 1, 32'h200, 1);
    step(1, 0, 0, 0, 1, 32'h204, 1);
    step(1, 0, 0, 0, 1, 32'h208, 1);
    // Stall on ack: instruction is parked, then released.
    step(1, 1, 0, 0, 1, 32'h20C, 1);
    step(0, 1, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 1, 32'h210, 1);
    // Branch coincident with ack: data squashed.
    step(1, 0, 1, 32'h40, 1, 32'h214, 0);
    step(1, 0, 0, 0, 1, 32'h40, 1);
    // Two branches during flush: the last target wins.
    step(0, 0, 1, 32'h500, 1, 32'h44, 0);
    step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h44, 0);
    step(1, 0, 0, 0, 1, 32'h44, 0);
    // Address wrap.
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 0, 1, 32'h0, 1);
    // Branch while holding discards the buffer.
    step(1, 1, 0, 0, 1, 32'h4, 0);
    step(0, 1, 1, 32'h80, 0, 32'h0, 0);
    step(1, 0, 0, 0, 1, 32'h80, 1);
    step(0, 0, 0, 0, 1, 32'h84, 0);
    step(0, 0, 0, 0, 1, 32'h84, 0);
`ifdef FETCH_PERF_EN
    check("fetch_cnt", {32'd0, fetch_cnt}, 64'd11);
    check("squash_cnt", {32'd0, squash_cnt}, 64'd4);
`endif
    // Reset mid-request drops req immediately; a late ack in idle is ignored.
    #2 rst_n = 1'b0;
    ack = 1'b1;
    #1 check("async_req_drop", {63'd0, req}, 64'd0);
    check("async_en", {63'd0, en}, 64'd0);
`ifdef FETCH_PERF_EN
    check("fetch_cnt_rst", {32'd0, fetch_cnt}, 64'd0);
    check("squash_cnt_rst", {32'd0, squash_cnt}, 64'd0);
`endif
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1, 32'h100, 0);
    step(1, 0, 0, 0, 1, 32'h100, 1);
    step(0, 0, 0, 0, 1, 32'h104, 0);
    step(0, 0, 0, 0, 1, 32'h104, 0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
